ls_issue_arbiter: RTL and testbench

//  Oldest-first arbiter that shares the single load/store port of the data-memory/store-FIFO unit between N_REQ

---
 rtl/ls_issue_arbiter.sv | 141 ++++++++++++++
 tb/tb_ls_issue_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_issue_arbiter.sv
// ls_issue_arbiter: oldest-first arbiter sharing the single load/store port of the
// data-memory/store-FIFO unit between N_REQ address-generation pipes. Each pipe owns
// one holding register; the oldest held op (by ROB age) is presented to memory, and a
// store blocked by a full store FIFO stalls everything behind it to keep program order.
module ls_issue_arbiter #(
  parameter int N_REQ = 2,
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int TW    = 5,
  parameter int PW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze_back,
  input  logic              full_FIFO,
  input  logic [TW-1:0]     rob_head,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [N_REQ-1:0]  req_mode,
  input  logic [N_REQ*DW-1:0] req_busX,
  input  logic [N_REQ*AW-1:0] req_Addr,
  input  logic [N_REQ*TW-1:0] req_tag,
  input  logic [N_REQ*PW-1:0] req_Px,
  output logic              valid_ls,
  output logic              mode,
  output logic [DW-1:0]     busX,
  output logic [AW-1:0]     Addr,
  output logic [TW-1:0]     tag_ROB_ls,
  output logic [PW-1:0]     Px,
  output logic [1:0]        grant_id,
  output logic [15:0]       cnt_full_stall
);

  // Saturating increment for the full-FIFO stall counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Holding registers (stage p0): one buffered request per pipe.
  logic [N_REQ-1:0] vld_p0;
  logic [N_REQ-1:0] mode_p0;
  logic [DW-1:0]    busx_p0 [N_REQ];
  logic [AW-1:0]    addr_p0 [N_REQ];
  logic [TW-1:0]    tag_p0  [N_REQ];
  logic [PW-1:0]    px_p0   [N_REQ];

  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] capture;
  logic             oldest_found;
  logic [1:0]       oldest_idx;
  logic [TW-1:0]    oldest_age;
  logic             oldest_mode;
  logic [TW-1:0]    age;
  logic             store_blocked;

  // Pick the oldest held op by modular ROB age; a blocked store grants nobody.
  always_comb begin
    oldest_found = 1'b0;
    oldest_idx   = 2'd0;
    oldest_age   = '0;
    oldest_mode  = 1'b0;
    age          = '0;
    for (int i = 0; i < N_REQ; i++) begin
      age = tag_p0[i] - rob_head;
      if (vld_p0[i] && (!oldest_found || age < oldest_age)) begin
        oldest_found = 1'b1;
        oldest_idx   = 2'(i);
        oldest_age   = age;
        oldest_mode  = mode_p0[i];
      end
    end
    store_blocked = oldest_found && !oldest_mode && full_FIFO;
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = oldest_found && !store_blocked && (oldest_idx == 2'(i));
    end
  end

  assign req_ready = ~{N_REQ{flush}} & (~vld_p0 | (grant & ~{N_REQ{freeze_back}}));
  assign capture   = req_valid & req_ready;

  // Memory-side outputs come straight from the granted holding register, zero otherwise.
  always_comb begin
    mode       = 1'b0;
    busX       = '0;
    Addr       = '0;
    tag_ROB_ls = '0;
    Px         = '0;
    grant_id   = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        mode       = mode_p0[i];
        busX       = busx_p0[i];
        Addr       = addr_p0[i];
        tag_ROB_ls = tag_p0[i];
        Px         = px_p0[i];
        grant_id   = 2'(i);
      end
    end
    valid_ls = (|grant) && !flush;
  end

  // Occupancy: flush wins, then refill, then release of an unfrozen grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= '0;
    end else if (flush) begin
      vld_p0 <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (capture[i])
          vld_p0[i] <= 1'b1;
        else if (grant[i] && !freeze_back)
          vld_p0[i] <= 1'b0;
      end
    end
  end

  // Payload capture; qualified by vld_p0 so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (capture[i]) begin
        mode_p0[i] <= req_mode[i];
        busx_p0[i] <= req_busX[i*DW +: DW];
        addr_p0[i] <= req_Addr[i*AW +: AW];
        tag_p0[i]  <= req_tag[i*TW +: TW];
        px_p0[i]   <= req_Px[i*PW +: PW];
      end
    end
  end

  // Count cycles in which the oldest op is a store held back by a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_full_stall <= 16'd0;
    else if (store_blocked && !flush)
      cnt_full_stall <= sat_inc(cnt_full_stall);
  end

endmodule

// File: tb/tb_ls_issue_arbiter.sv
// tb_ls_issue_arbiter: directed stimulus for ls_issue_arbiter with a behavioural
// reference model compared every cycle, plus hand-computed checkpoints.
module tb_ls_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        freeze_back = 1'b0;
  logic        full_FIFO = 1'b0;
  logic [4:0]  rob_head = '0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_mode = '0;
  logic [31:0] req_busX = '0;
  logic [31:0] req_Addr = '0;
  logic [9:0]  req_tag = '0;
  logic [9:0]  req_Px = '0;
  logic        valid_ls;
  logic        mode;
  logic [15:0] busX;
  logic [15:0] Addr;
  logic [4:0]  tag_ROB_ls;
  logic [4:0]  Px;
  logic [1:0]  grant_id;
  logic [15:0] cnt_full_stall;

  int vectors = 0;
  int fails   = 0;

  ls_issue_arbiter #(.N_REQ(2), .DW(16), .AW(16), .TW(5), .PW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back), .full_FIFO(full_FIFO),
    .rob_head(rob_head), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_busX(req_busX), .req_Addr(req_Addr), .req_tag(req_tag), .req_Px(req_Px),
    .valid_ls(valid_ls), .mode(mode), .busX(busX), .Addr(Addr), .tag_ROB_ls(tag_ROB_ls),
    .Px(Px), .grant_id(grant_id), .cnt_full_stall(cnt_full_stall)
  );

  always #5 clk = ~clk;

  // Reference model: set of buffered ops per pipe and the stall count.
  logic        mv [2];
  logic        mmode [2];
  logic [15:0] mbus [2];
  logic [15:0] maddr [2];
  logic [4:0]  mtag [2];
  logic [4:0]  mpx [2];
  logic [15:0] mcnt;

  function automatic int exp_oldest();
    int best = -1;
    int best_age = 0;
    int a;
    for (int i = 0; i < 2; i++) begin
      if (mv[i] === 1'b1) begin
        a = (int'(mtag[i]) - int'(rob_head) + 32) % 32;
        if (best < 0 || a < best_age) begin
          best = i;
          best_age = a;
        end
      end
    end
    return best;
  endfunction

  function automatic int exp_grant();
    int o = exp_oldest();
    if (o >= 0 && (mmode[o] || !full_FIFO)) return o;
    return -1;
  endfunction

  function automatic logic exp_ready(input int i);
    return !flush && (!(mv[i] === 1'b1) || (exp_grant() == i && !freeze_back));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mv[i] <= 1'b0;
      mcnt <= 16'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flush)
          mv[i] <= 1'b0;
        else if (req_valid[i] && exp_ready(i)) begin
          mv[i]    <= 1'b1;
          mmode[i] <= req_mode[i];
          mbus[i]  <= req_busX[i*16 +: 16];
          maddr[i] <= req_Addr[i*16 +: 16];
          mtag[i]  <= req_tag[i*5 +: 5];
          mpx[i]   <= req_Px[i*5 +: 5];
        end else if (exp_grant() == i && !freeze_back)
          mv[i] <= 1'b0;
      end
      if (exp_oldest() >= 0 && !mmode[exp_oldest()] && full_FIFO && !flush && mcnt != 16'hFFFF)
        mcnt <= mcnt + 16'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int g;
    g = exp_grant();
    chk("m_valid_ls", 32'(valid_ls), 32'(g >= 0 && !flush));
    chk("m_grant_id", 32'(grant_id), (g >= 0) ? 32'(g) : 32'd0);
    chk("m_req_ready", 32'(req_ready), {30'd0, exp_ready(1), exp_ready(0)});
    chk("m_cnt", 32'(cnt_full_stall), 32'(mcnt));
    chk("m_mode", 32'(mode), (g >= 0) ? 32'(mmode[g]) : 32'd0);
    chk("m_busX", 32'(busX), (g >= 0) ? 32'(mbus[g]) : 32'd0);
    chk("m_Addr", 32'(Addr), (g >= 0) ? 32'(maddr[g]) : 32'd0);
    chk("m_tag", 32'(tag_ROB_ls), (g >= 0) ? 32'(mtag[g]) : 32'd0);
    chk("m_Px", 32'(Px), (g >= 0) ? 32'(mpx[g]) : 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic m, input logic [15:0] d,
                         input logic [15:0] a, input logic [4:0] t, input logic [4:0] p);
    req_valid[i] = v;
    req_mode[i] = m;
    req_busX[i*16 +: 16] = d;
    req_Addr[i*16 +: 16] = a;
    req_tag[i*5 +: 5] = t;
    req_Px[i*5 +: 5] = p;
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    #2;
    chk("rst_ready", 32'(req_ready), 32'h3);
    chk("rst_valid", 32'(valid_ls), 32'h0);
    chk("rst_cnt", 32'(cnt_full_stall), 32'h0);
    chk("rst_addr", 32'(Addr), 32'h0);

    // Two loads, pipe1 older.
    set_req(0, 1, 1, 16'h0, 16'h10, 5'd3, 5'd4);
    set_req(1, 1, 1, 16'h0, 16'h20, 5'd1, 5'd6);
    step();
    req_valid = 2'b00;
    #2;
    chk("t1_gid_a", 32'(grant_id), 32'd1);
    chk("t1_addr_a", 32'(Addr), 32'h20);
    chk("t1_px_a", 32'(Px), 32'd6);
    step(); #2;
    chk("t1_gid_b", 32'(grant_id), 32'd0);
    chk("t1_addr_b", 32'(Addr), 32'h10);
    step(); #2;
    chk("t1_idle", 32'(valid_ls), 32'd0);

    // Oldest store blocked by full FIFO; younger load must wait.
    full_FIFO = 1'b1;
    set_req(0, 1, 0, 16'hBEEF, 16'h30, 5'd2, 5'd0);
    set_req(1, 1, 1, 16'h0, 16'h40, 5'd5, 5'd7);
    step();
    req_valid = 2'b00;
    #2;
    chk("t2_valid_a", 32'(valid_ls), 32'd0);
    chk("t2_cnt_a", 32'(cnt_full_stall), 32'd0);
    step(); #2;
    chk("t2_valid_b", 32'(valid_ls), 32'd0);
    chk("t2_cnt_b", 32'(cnt_full_stall), 32'd1);
    step(); #2;
    chk("t2_cnt_c", 32'(cnt_full_stall), 32'd2);
    chk("t2_ready", 32'(req_ready), 32'd0);
    step();
    full_FIFO = 1'b0;
    #2;
    chk("t2_st_valid", 32'(valid_ls), 32'd1);
    chk("t2_st_gid", 32'(grant_id), 32'd0);
    chk("t2_st_mode", 32'(mode), 32'd0);
    chk("t2_st_busX", 32'(busX), 32'hBEEF);
    chk("t2_cnt_d", 32'(cnt_full_stall), 32'd3);
    step(); #2;
    chk("t2_ld_gid", 32'(grant_id), 32'd1);
    chk("t2_ld_mode", 32'(mode), 32'd1);
    step();

    // Tag wrap-around: rob_head 30, tag 31 older than tag 2.
    rob_head = 5'd30;
    set_req(0, 1, 1, 16'h0, 16'h50, 5'd2, 5'd1);
    set_req(1, 1, 1, 16'h0, 16'h60, 5'd31, 5'd2);
    step();
    req_valid = 2'b00;
    #2;
    chk("t3_gid_a", 32'(grant_id), 32'd1);
    chk("t3_addr_a", 32'(Addr), 32'h60);
    step(); #2;
    chk("t3_gid_b", 32'(grant_id), 32'd0);
    chk("t3_addr_b", 32'(Addr), 32'h50);
    step();
    rob_head = 5'd0;

    // Freeze holds the grant for three cycles.
    set_req(0, 1, 1, 16'h0, 16'h70, 5'd4, 5'd3);
    step();
    req_valid = 2'b00;
    freeze_back = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t4_frz_valid", 32'(valid_ls), 32'd1);
      chk("t4_frz_addr", 32'(Addr), 32'h70);
      chk("t4_frz_ready0", 32'(req_ready[0]), 32'd0);
      step();
    end
    freeze_back = 1'b0;
    #2;
    chk("t4_rel_valid", 32'(valid_ls), 32'd1);
    chk("t4_rel_ready0", 32'(req_ready[0]), 32'd1);
    step(); #2;
    chk("t4_after", 32'(valid_ls), 32'd0);

    // Flush with both pipes held.
    set_req(0, 1, 1, 16'h0, 16'h80, 5'd8, 5'd1);
    set_req(1, 1, 1, 16'h0, 16'h90, 5'd9, 5'd2);
    step();
    req_valid = 2'b00;
    flush = 1'b1;
    #2;
    chk("t5_fl_valid", 32'(valid_ls), 32'd0);
    chk("t5_fl_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    #2;
    chk("t5_post_valid", 32'(valid_ls), 32'd0);
    chk("t5_post_ready", 32'(req_ready), 32'h3);
    chk("t5_cnt_kept", 32'(cnt_full_stall), 32'd3);

    // Back-to-back stream on pipe0.
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1, 1, 16'h0, 16'h100 + 16'(k), 5'(k), 5'd0);
      #2;
      if (k > 0) begin
        chk("t6_valid", 32'(valid_ls), 32'd1);
        chk("t6_addr", 32'(Addr), 32'h100 + 32'(k - 1));
        chk("t6_ready0", 32'(req_ready[0]), 32'd1);
      end
      step();
    end
    req_valid = 2'b00;
    #2;
    chk("t6_last", 32'(Addr), 32'h105);
    step(); #2;
    chk("t6_idle", 32'(valid_ls), 32'd0);

    // Long full-FIFO stall: counter saturates, younger load never bypasses.
    full_FIFO = 1'b1;
    set_req(0, 1, 0, 16'h1234, 16'hA0, 5'd1, 5'd0);
    set_req(1, 1, 1, 16'h0, 16'hB0, 5'd2, 5'd5);
    step();
    req_valid = 2'b00;
    repeat (65540) step();
    #2;
    chk("t7_sat", 32'(cnt_full_stall), 32'hFFFF);
    chk("t7_nobypass", 32'(valid_ls), 32'd0);

    // Asynchronous reset mid-operation.
    rst = 1'b1;
    #1;
    chk("t8_cnt", 32'(cnt_full_stall), 32'd0);
    chk("t8_valid", 32'(valid_ls), 32'd0);
    chk("t8_ready", 32'(req_ready), 32'h3);
    step();
    rst = 1'b0;
    full_FIFO = 1'b0;
    #2;
    chk("t8_lost", 32'(valid_ls), 32'd0);
    step(); #2;
    chk("t8_lost2", 32'(grant_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
